// File: rtl/tag_stream_serializer.sv
// tag_stream_serializer: buffers fixed-width timetag records in a FIFO and
// streams them LSB byte first onto the output mux writer interface.
// Optional: define TAG_STREAM_SERIALIZER_LOST_COUNT_EN to count records
// dropped while the FIFO is full (saturating 16-bit counter).
module tag_stream_serializer #(
  parameter int RECORD_BYTES    = 6,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [RECORD_BYTES*8-1:0]   rec_i,
  input  logic                        rec_valid_i,
  output logic                        full_o,
  output logic [FIFO_DEPTH_LOG2:0]    fill_o,
  output logic [7:0]                  omux_data_o,
  output logic                        omux_req_o,
  input  logic                        omux_sel_i,
  output logic [15:0]                 lost_count_o
);

  localparam int RW    = RECORD_BYTES * 8;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int IW    = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
  localparam logic [IW-1:0]              LAST   = IW'(RECORD_BYTES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTHC = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [DEPTH-1:0][RW-1:0]     mem;
  logic [FIFO_DEPTH_LOG2-1:0]   wptr, rptr;
  logic [FIFO_DEPTH_LOG2:0]     cnt, cnt_nxt;
  logic                         full_q;

  // output stage
  logic [RECORD_BYTES-1:0][7:0] rec_q;
  logic [IW-1:0]                idx;
  logic                         vld;

  logic wr, pop, last_sel, empty;

  // write/pop decisions; full is the registered pre-edge flag, so a drop
  // on full holds even when a pop happens in the same cycle
  always_comb begin
    wr       = rec_valid_i & ~full_q;
    empty    = (cnt == '0);
    last_sel = vld & omux_sel_i & (idx == LAST);
    pop      = (~vld | last_sel) & ~empty;
    cnt_nxt  = cnt + (FIFO_DEPTH_LOG2+1)'(wr) - (FIFO_DEPTH_LOG2+1)'(pop);
  end

  // record storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= rec_i;
  end

  // pointers, occupancy and registered full flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt    <= cnt_nxt;
      full_q <= (cnt_nxt == DEPTHC);
    end
  end

  // output stage: load head record, step byte index on sel, chain records
  // back to back on last-byte sel when more are queued
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rec_q <= '0;
      idx   <= '0;
      vld   <= 1'b0;
    end else if (pop) begin
      rec_q <= mem[rptr];
      idx   <= '0;
      vld   <= 1'b1;
    end else if (vld && omux_sel_i) begin
      if (idx == LAST) vld <= 1'b0;
      else             idx <= idx + 1'b1;
    end
  end

  assign full_o      = full_q;
  assign fill_o      = cnt;
  assign omux_req_o  = vld;
  assign omux_data_o = rec_q[idx];

`ifdef TAG_STREAM_SERIALIZER_LOST_COUNT_EN
  logic [15:0] lost_q;

  // saturating count of records dropped on full
  always_ff @(posedge clk_i) begin
    if (reset_i)                                         lost_q <= '0;
    else if (rec_valid_i && full_q && lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
  end

  assign lost_count_o = lost_q;
`else
  assign lost_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_tag_stream_serializer.sv
// tb_tag_stream_serializer: directed + random stimulus against a queue-based
// reference model of the serializer and a byte-order scoreboard.
module tb_tag_stream_serializer;
  localparam int RB    = 6;
  localparam int LG    = 4;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          reset_i, rec_valid_i, omux_sel_i;
  logic [RB*8-1:0] rec_i;
  logic          full_o, omux_req_o;
  logic [LG:0]   fill_o;
  logic [7:0]    omux_data_o;
  logic [15:0]   lost_count_o;

  tag_stream_serializer #(.RECORD_BYTES(RB), .FIFO_DEPTH_LOG2(LG)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rec_i(rec_i), .rec_valid_i(rec_valid_i),
    .full_o(full_o), .fill_o(fill_o), .omux_data_o(omux_data_o),
    .omux_req_o(omux_req_o), .omux_sel_i(omux_sel_i), .lost_count_o(lost_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: FIFO as a queue, output stage as (record, byte, busy)
  logic [RB*8-1:0] q[$];
  logic [7:0]      bq[$];   // every accepted byte, in expected wire order
  bit              have = 0;
  int              bidx = 0;
  logic [RB*8-1:0] cur  = '0;
  int              lost = 0;
  bit              lost_en;

  initial begin
`ifdef TAG_STREAM_SERIALIZER_LOST_COUNT_EN
    lost_en = 1;
`else
    lost_en = 0;
`endif
  end

  // one clock: drive at negedge, check pre-edge outputs, advance model, return after edge
  task automatic cyc(input bit r, input bit v, input logic [RB*8-1:0] d, input bit s);
    bit full_pre;
    @(negedge clk_i);
    reset_i = r; rec_valid_i = v; rec_i = d; omux_sel_i = s;
    #1;
    chk("req",  omux_req_o, have);
    chk("fill", fill_o, q.size());
    chk("full", full_o, q.size() == DEPTH);
    chk("lost", lost_count_o, lost);
    if (have) chk("data", omux_data_o, cur[8*bidx +: 8]);
    if (have && s && !r) begin
      chk("stream_len", bq.size() > 0, 1);
      if (bq.size() > 0) chk("stream", omux_data_o, bq.pop_front());
    end
    full_pre = (q.size() == DEPTH);
    if (r) begin
      q.delete(); bq.delete(); have = 0; bidx = 0; cur = '0; lost = 0;
    end else begin
      if (!have) begin
        if (q.size() > 0) begin cur = q.pop_front(); bidx = 0; have = 1; end
      end else if (s) begin
        if (bidx < RB-1)      bidx++;
        else if (q.size() > 0) begin cur = q.pop_front(); bidx = 0; end
        else                   have = 0;
      end
      if (v && !full_pre) begin
        q.push_back(d);
        for (int b = 0; b < RB; b++) bq.push_back(d[8*b +: 8]);
      end
      if (v && full_pre && lost_en && lost < 16'hFFFF) lost++;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0);
  endtask

  logic [RB*8-1:0] rr;
  int pv, ps;

  initial begin
    reset_i = 1; rec_valid_i = 0; rec_i = '0; omux_sel_i = 0;
    repeat (2) @(posedge clk_i);
    cyc(1, 0, '0, 0);
    chk("rst_req",  omux_req_o, 0);
    chk("rst_data", omux_data_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_lost", lost_count_o, 0);

    // single record, sel every third cycle
    cyc(0, 1, 48'h060504030201, 0);
    cyc(0, 0, '0, 0);
    chk("lat_req", omux_req_o, 1);
    for (int i = 0; i < RB; i++) begin cyc(0,0,'0,0); cyc(0,0,'0,0); cyc(0,0,'0,1); end
    chk("single_req_off", omux_req_o, 0);
    chk("single_fill", fill_o, 0);
    idle(2);

    // back to back, sel held high
    cyc(0, 1, 48'hA5A4A3A2A1A0, 1);
    cyc(0, 1, 48'hB5B4B3B2B1B0, 1);
    for (int i = 0; i < 2*RB; i++) begin
      chk("b2b_req", omux_req_o, 1);
      cyc(0, 0, '0, 1);
    end
    chk("b2b_req_off", omux_req_o, 0);
    idle(2);

    // overflow: 18 writes, no sel
    for (int i = 0; i < 18; i++) cyc(0, 1, {16'hC0DE, 32'(i)}, 0);
    idle(1);
    chk("ovf_fill", fill_o, 16);
    chk("ovf_full", full_o, 1);
    chk("ovf_lost", lost_count_o, lost_en ? 1 : 0);

    // write while full coincident with last-byte sel
    for (int i = 0; i < RB-1; i++) cyc(0, 0, '0, 1);
    cyc(0, 1, 48'hDEADDEADDEAD, 1);
    chk("sim_fill", fill_o, 15);
    chk("sim_full", full_o, 0);
    chk("sim_lost", lost_count_o, lost_en ? 2 : 0);
    for (int i = 0; i < 16*RB + 2; i++) cyc(0, 0, '0, 1);
    chk("drain_left", bq.size(), 0);

    // reset mid-record
    cyc(0, 1, 48'h161514131211, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 0);
    chk("mid_rst_req", omux_req_o, 0);
    chk("mid_rst_fill", fill_o, 0);
    cyc(0, 1, 48'h262524232221, 0);
    for (int i = 0; i < RB + 2; i++) cyc(0, 0, '0, 1);

    // randomized traffic with shifting write/sel densities
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin pv = $urandom_range(10, 95); ps = $urandom_range(10, 100); end
      rr = {$urandom, $urandom};
      cyc(($urandom % 700) == 0, ($urandom % 100) < pv, rr, ($urandom % 100) < ps);
    end
    for (int i = 0; i < 17*RB + 4; i++) cyc(0, 0, '0, 1);

    if (lost_en) begin
      // saturation: fill, then hammer writes with no sel
      cyc(1, 0, '0, 0);
      for (int i = 0; i < 70000; i++) cyc(0, 1, 48'h5A5A5A5A5A5A, 0);
      chk("sat_lost", lost_count_o, 16'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
